uart_rx_drain_ctrl: RTL and testbench

Read-side controller for the UART receive wrapper's 12-bit status FIFO. It pops FIFO entries, decodes the error flags and keeps saturating per-error counters. Clean bytes, and optionally errored ones, are delivered to a downstream consumer over a valid/ready handshake. It sits between the UART receive wrapper and the host/bus-side logic.

---
 rtl/uart_rx_drain_ctrl.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_drain_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_drain_ctrl.sv
// uart_rx_drain_ctrl
//   Read-side controller for the UART receive wrapper's 12-bit status FIFO.
//   Pops FIFO words, decodes FE/PE/BE flags, keeps saturating per-error
//   counters and delivers bytes (optionally dropping errored ones) to a
//   downstream consumer over a valid/ready handshake.
//
//   Optional feature macro: UART_RX_IRQ_EN (adds irq_mask/irq_ack/irq).
//
// Ports
//   UART_clk            system clock
//   rst                 synchronous active-high reset
//   empty               FIFO empty flag
//   rd_data[11:0]       FIFO word: [7:0] data, [8] FE, [9] PE, [10] rsvd, [11] BE
//   rd_en               FIFO pop strobe (rd_data valid the following cycle)
//   drop_err_en/cfg_we  drop-policy write value / write strobe
//   cnt_clr             synchronous clear of all counters
//   m_data/m_flags      delivered byte / flags {BE,PE,FE}
//   m_valid/m_ready     downstream handshake
//   frm/fe/pe/be/drop_cnt  saturating counters
//   irq_mask/irq_ack/irq   sticky error interrupt (UART_RX_IRQ_EN only)
module uart_rx_drain_ctrl #(
    parameter int unsigned CNT_W        = 8,
    parameter bit          DROP_DEFAULT = 1'b0
) (
    input  logic             UART_clk,
    input  logic             rst,
    input  logic             empty,
    input  logic [11:0]      rd_data,
    output logic             rd_en,
    input  logic             drop_err_en,
    input  logic             cfg_we,
    input  logic             cnt_clr,
    output logic [7:0]       m_data,
    output logic [2:0]       m_flags,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] frm_cnt,
    output logic [CNT_W-1:0] fe_cnt,
    output logic [CNT_W-1:0] pe_cnt,
    output logic [CNT_W-1:0] be_cnt,
    output logic [CNT_W-1:0] drop_cnt
`ifdef UART_RX_IRQ_EN
    ,
    input  logic [2:0]       irq_mask,
    input  logic             irq_ack,
    output logic             irq
`endif
);

    typedef enum logic [1:0] {IDLE, POP, CAPT, PRESENT} state_t;

    state_t           r_state;
    logic             r_rd_en;
    logic             r_valid;
    logic [7:0]       r_data;
    logic [2:0]       r_flags;
    logic             r_drop;
    logic [CNT_W-1:0] r_frm_cnt;
    logic [CNT_W-1:0] r_fe_cnt;
    logic [CNT_W-1:0] r_pe_cnt;
    logic [CNT_W-1:0] r_be_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [2:0]       w_flags;
    logic             w_drop;
    logic             w_unused_rsvd;

    assign w_flags       = {rd_data[11], rd_data[9], rd_data[8]};
    assign w_drop        = (w_flags != 3'b000) && r_drop;
    assign w_unused_rsvd = rd_data[10];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Control FSM; rd_en is asserted on entry to POP so it is high for exactly
    // the POP cycle, and rd_data is captured one cycle later in CAPT.
    always_ff @(posedge UART_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rd_en <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_flags <= '0;
            r_drop  <= DROP_DEFAULT;
        end else begin
            if (cfg_we) begin
                r_drop <= drop_err_en;
            end
            r_rd_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!empty) begin
                        r_state <= POP;
                        r_rd_en <= 1'b1;
                    end
                end
                POP: begin
                    r_state <= CAPT;
                end
                CAPT: begin
                    if (w_drop) begin
                        r_state <= IDLE;
                    end else begin
                        r_data  <= rd_data[7:0];
                        r_flags <= w_flags;
                        r_valid <= 1'b1;
                        r_state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (r_valid && m_ready) begin
                        r_valid <= 1'b0;
                        if (!empty) begin
                            r_state <= POP;
                            r_rd_en <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Counters: clear wins over any increment in the same cycle.
    always_ff @(posedge UART_clk) begin
        if (rst || cnt_clr) begin
            r_frm_cnt  <= '0;
            r_fe_cnt   <= '0;
            r_pe_cnt   <= '0;
            r_be_cnt   <= '0;
            r_drop_cnt <= '0;
        end else if (r_state == CAPT) begin
            r_frm_cnt  <= sat_inc(r_frm_cnt, 1'b1);
            r_fe_cnt   <= sat_inc(r_fe_cnt, w_flags[0]);
            r_pe_cnt   <= sat_inc(r_pe_cnt, w_flags[1]);
            r_be_cnt   <= sat_inc(r_be_cnt, w_flags[2]);
            r_drop_cnt <= sat_inc(r_drop_cnt, w_drop);
        end
    end

`ifdef UART_RX_IRQ_EN
    logic r_irq;

    // Set has priority over acknowledge.
    always_ff @(posedge UART_clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if ((r_state == CAPT) && ((w_flags & irq_mask) != 3'b000)) begin
            r_irq <= 1'b1;
        end else if (irq_ack) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif

    assign rd_en    = r_rd_en;
    assign m_valid  = r_valid;
    assign m_data   = r_data;
    assign m_flags  = r_flags;
    assign frm_cnt  = r_frm_cnt;
    assign fe_cnt   = r_fe_cnt;
    assign pe_cnt   = r_pe_cnt;
    assign be_cnt   = r_be_cnt;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// tb_uart_rx_drain_ctrl
//   Scoreboard bench for uart_rx_drain_ctrl. A FIFO model feeds both a
//   CNT_W=8 instance and a CNT_W=2 instance (for saturation); expected
//   {flags,data} words are queued at push time and compared on handshake.
module tb_uart_rx_drain_ctrl;

    logic        UART_clk = 1'b0;
    logic        rst;
    logic        empty;
    logic [11:0] rd_data;
    logic        drop_err_en;
    logic        cfg_we;
    logic        cnt_clr;
    logic        m_ready;

    logic        rd_en, m_valid;
    logic [7:0]  m_data;
    logic [2:0]  m_flags;
    logic [7:0]  frm_cnt, fe_cnt, pe_cnt, be_cnt, drop_cnt;

    logic        rd_en2, m_valid2;
    logic [7:0]  m_data2;
    logic [2:0]  m_flags2;
    logic [1:0]  frm_cnt2, fe_cnt2, pe_cnt2, be_cnt2, drop_cnt2;

`ifdef UART_RX_IRQ_EN
    logic [2:0]  irq_mask;
    logic        irq_ack;
    logic        irq, irq2;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned rd_cnt   = 0;

    logic [11:0] pend_q[$];
    logic [11:0] fifo_q[$];
    logic [10:0] exp_q[$];

    logic        hold_prev = 1'b0;
    logic [10:0] hold_word = '0;

    always #5 UART_clk = ~UART_clk;

    uart_rx_drain_ctrl #(.CNT_W(8), .DROP_DEFAULT(1'b0)) u_dut (
        .UART_clk(UART_clk), .rst(rst), .empty(empty), .rd_data(rd_data),
        .rd_en(rd_en), .drop_err_en(drop_err_en), .cfg_we(cfg_we),
        .cnt_clr(cnt_clr), .m_data(m_data), .m_flags(m_flags),
        .m_valid(m_valid), .m_ready(m_ready), .frm_cnt(frm_cnt),
        .fe_cnt(fe_cnt), .pe_cnt(pe_cnt), .be_cnt(be_cnt), .drop_cnt(drop_cnt)
`ifdef UART_RX_IRQ_EN
        , .irq_mask(irq_mask), .irq_ack(irq_ack), .irq(irq)
`endif
    );

    uart_rx_drain_ctrl #(.CNT_W(2), .DROP_DEFAULT(1'b0)) u_dut2 (
        .UART_clk(UART_clk), .rst(rst), .empty(empty), .rd_data(rd_data),
        .rd_en(rd_en2), .drop_err_en(drop_err_en), .cfg_we(cfg_we),
        .cnt_clr(cnt_clr), .m_data(m_data2), .m_flags(m_flags2),
        .m_valid(m_valid2), .m_ready(m_ready), .frm_cnt(frm_cnt2),
        .fe_cnt(fe_cnt2), .pe_cnt(pe_cnt2), .be_cnt(be_cnt2), .drop_cnt(drop_cnt2)
`ifdef UART_RX_IRQ_EN
        , .irq_mask(irq_mask), .irq_ack(irq_ack), .irq(irq2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model: pops on rd_en, data appears the following cycle.
    always @(posedge UART_clk) begin
        if (rd_en) begin
            check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) rd_data <= fifo_q.pop_front();
        end
        while (pend_q.size() != 0) fifo_q.push_back(pend_q.pop_front());
        empty <= (fifo_q.size() == 0);
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge UART_clk) begin
        logic [10:0] e;
        if (rd_en) rd_cnt++;
        if (hold_prev) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_word", 32'({m_flags, m_data}), 32'(hold_word));
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 32'({m_flags, m_data}), 32'h7ff_0000);
            end else begin
                e = exp_q.pop_front();
                check("sb_word", 32'({m_flags, m_data}), 32'(e));
            end
        end
        hold_prev = m_valid && !m_ready && !rst;
        hold_word = {m_flags, m_data};
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge UART_clk);
            #2;
        end
    endtask

    task automatic push(input logic [11:0] w, input bit deliver);
        pend_q.push_back(w);
        if (deliver) exp_q.push_back({w[11], w[9], w[8], w[7:0]});
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((pend_q.size() != 0 || fifo_q.size() != 0 || exp_q.size() != 0 || m_valid)
               && n < 300) begin
            cyc(1);
            n++;
        end
        check("drain_timeout", 32'(n < 300), 32'd1);
        cyc(3);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!m_valid && n < 50) begin
            cyc(1);
            n++;
        end
        check("valid_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic set_policy(input logic p);
        drop_err_en = p;
        cfg_we      = 1'b1;
        cyc(1);
        cfg_we      = 1'b0;
        drop_err_en = 1'b0;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unsigned r0;
        rst = 1'b1; empty = 1'b1; rd_data = '0; drop_err_en = 1'b0;
        cfg_we = 1'b0; cnt_clr = 1'b0; m_ready = 1'b0;
`ifdef UART_RX_IRQ_EN
        irq_mask = 3'b000; irq_ack = 1'b0;
`endif
        cyc(3);
        // Reset state
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'({m_flags, m_data}), 32'd0);
        check("rst_cnts", {frm_cnt, fe_cnt, pe_cnt, be_cnt}, 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        cyc(1);

        // Single clean word and latency
        m_ready = 1'b1;
        r0 = rd_cnt;
        push(12'h0A5, 1'b1);
        n = 0;
        while (empty && n < 10) begin cyc(1); n++; end
        n = 0;
        while (!m_valid && n < 10) begin cyc(1); n++; end
        check("latency", 32'(n), 32'd3);
        check("first_data", 32'(m_data), 32'hA5);
        wait_drain();
        check("single_rd_pulses", rd_cnt - r0, 32'd1);
        check("single_frm", 32'(frm_cnt), 32'd1);
        check("single_errs", 32'({fe_cnt, pe_cnt, be_cnt, drop_cnt}), 32'd0);

        // Backpressure with a second word queued behind
        m_ready = 1'b0;
        r0 = rd_cnt;
        push(12'h15A, 1'b1);
        wait_valid();
        push(12'h0C3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("bp_valid", 32'(m_valid), 32'd1);
            check("bp_data", 32'(m_data), 32'h5A);
        end
        check("bp_rd_pulses", rd_cnt - r0, 32'd1);
        m_ready = 1'b1;
        wait_drain();
        check("bp_rd_after", rd_cnt - r0, 32'd2);
        check("bp_frm", 32'(frm_cnt), 32'd3);

        // Drop policy; rd_data[10] alone is not an error
        clear_cnt();
        set_policy(1'b1);
        push(12'h23C, 1'b0);
        push(12'h910, 1'b0);
        push(12'h4A5, 1'b1);
        wait_drain();
        check("drop_pe", 32'(pe_cnt), 32'd1);
        check("drop_be", 32'(be_cnt), 32'd1);
        check("drop_fe", 32'(fe_cnt), 32'd1);
        check("drop_cnt", 32'(drop_cnt), 32'd2);
        check("drop_frm", 32'(frm_cnt), 32'd3);

        // Deliver errored word with policy off
        clear_cnt();
        set_policy(1'b0);
        push(12'h300, 1'b1);
        wait_drain();
        check("deliv_pe_fe", 32'({pe_cnt, fe_cnt}), 32'h0101);
        check("deliv_drop", 32'({be_cnt, drop_cnt}), 32'd0);

        // Saturation and clear colliding with CAPT
        clear_cnt();
        for (int i = 1; i <= 5; i++) push(12'h100 | 12'(i), 1'b1);
        wait_drain();
        check("sat_fe8", 32'(fe_cnt), 32'd5);
        check("sat_frm8", 32'(frm_cnt), 32'd5);
        check("sat_fe2", 32'(fe_cnt2), 32'd3);
        check("sat_frm2", 32'(frm_cnt2), 32'd3);
        check("sat_pe2", 32'(pe_cnt2), 32'd0);
        push(12'h106, 1'b1);
        cyc(3);
        cnt_clr = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
        check("clr_capt_align", 32'(m_valid), 32'd1);
        check("clr_fe8", 32'(fe_cnt), 32'd0);
        check("clr_fe2", 32'(fe_cnt2), 32'd0);
        check("clr_frm", 32'({frm_cnt, 6'd0, frm_cnt2}), 32'd0);
        wait_drain();

        // Reset while presenting
        m_ready = 1'b0;
        push(12'h0EE, 1'b0);
        wait_valid();
        check("pre_rst_frm", 32'(frm_cnt), 32'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_mid_valid", 32'(m_valid), 32'd0);
        check("rst_mid_word", 32'({m_flags, m_data}), 32'd0);
        check("rst_mid_frm", 32'(frm_cnt), 32'd0);
        m_ready = 1'b1;
        push(12'h455, 1'b1);
        wait_drain();
        check("post_rst_frm", 32'(frm_cnt), 32'd1);

`ifdef UART_RX_IRQ_EN
        irq_mask = 3'b001;
        push(12'h200, 1'b1);
        wait_drain();
        check("irq_masked", 32'(irq), 32'd0);
        push(12'h1FF, 1'b1);
        wait_drain();
        check("irq_set", 32'(irq), 32'd1);
        cyc(2);
        check("irq_sticky", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        check("irq_ack", 32'(irq), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
